// File: rtl/router_ingress_arbiter.sv
// Round-robin ingress arbiter sharing the router input port between three
// packet sources; grants whole packets and tracks the header length.
module router_ingress_arbiter #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] src_pkt_valid,
  input  logic [7:0] src_data_0,
  input  logic [7:0] src_data_1,
  input  logic [7:0] src_data_2,
  output logic [2:0] src_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic [2:0] grant,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] grant_n;
  logic [1:0] rr_ptr, rr_ptr_n;
  logic [5:0] rem, rem_n;
  logic [2:0] gap_cnt, gap_cnt_n;
  logic       err_n;
  logic       fwd, accept, pkt_end;
  logic       g_valid;
  logic [7:0] g_data;
  logic [2:0] pick;
  logic [1:0] rr_next;

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    unique case (1'b1)
      grant[0]: begin
        g_data  = src_data_0;
        g_valid = src_pkt_valid[0];
      end
      grant[1]: begin
        g_data  = src_data_1;
        g_valid = src_pkt_valid[1];
      end
      grant[2]: begin
        g_data  = src_data_2;
        g_valid = src_pkt_valid[2];
      end
      default: ;
    endcase
  end

  // First requester at or after rr_ptr, wrapping mod 3
  always_comb begin
    pick = '0;
    case (rr_ptr)
      2'd1: begin
        if (src_pkt_valid[1])      pick = 3'b010;
        else if (src_pkt_valid[2]) pick = 3'b100;
        else if (src_pkt_valid[0]) pick = 3'b001;
      end
      2'd2: begin
        if (src_pkt_valid[2])      pick = 3'b100;
        else if (src_pkt_valid[0]) pick = 3'b001;
        else if (src_pkt_valid[1]) pick = 3'b010;
      end
      default: begin
        if (src_pkt_valid[0])      pick = 3'b001;
        else if (src_pkt_valid[1]) pick = 3'b010;
        else if (src_pkt_valid[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    rr_next = 2'd0;
    unique case (1'b1)
      grant[0]: rr_next = 2'd1;
      grant[1]: rr_next = 2'd2;
      default:  rr_next = 2'd0;
    endcase
  end

  assign fwd       = (state == HDR) || (state == PAYLOAD) ||
                     (state == PARITY);
  assign accept    = fwd && !busy;
  assign src_ready = accept ? grant : 3'b000;
  assign data_in   = fwd ? g_data : 8'h00;
  assign pkt_valid = ((state == HDR) || (state == PAYLOAD)) && g_valid;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    rr_ptr_n  = rr_ptr;
    rem_n     = rem;
    gap_cnt_n = gap_cnt;
    err_n     = 1'b0;
    pkt_end   = 1'b0;
    case (state)
      IDLE: begin
        if (|src_pkt_valid) begin
          grant_n = pick;
          state_n = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          if (!g_valid) begin
            err_n   = 1'b1;
            pkt_end = 1'b1;
          end else if (data_in[7:2] == 6'd0) begin
            err_n   = 1'b1;
            state_n = PARITY;
          end else begin
            rem_n   = data_in[7:2];
            state_n = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (!g_valid) begin
            err_n   = 1'b1;
            pkt_end = 1'b1;
          end else begin
            rem_n = rem - 6'd1;
            if (rem == 6'd1) state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (accept) begin
          err_n   = g_valid;
          pkt_end = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + 3'd1;
      end
      default: state_n = IDLE;
    endcase
    if (pkt_end) begin
      state_n   = GAP;
      grant_n   = 3'b000;
      rr_ptr_n  = rr_next;
      gap_cnt_n = 3'd0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= 3'b000;
      rr_ptr    <= 2'd0;
      rem       <= 6'd0;
      gap_cnt   <= 3'd0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      rr_ptr    <= rr_ptr_n;
      rem       <= rem_n;
      gap_cnt   <= gap_cnt_n;
      proto_err <= err_n;
    end
  end

endmodule
